// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, sequences one-outstanding imem fetches and hands instructions to decode
module pc_fetch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
  logic [1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d, tgt;
  logic kill_q, kill_d, grace_q, grace_d, req_fire, if_fire;
  assign tgt = redirect_target & ~DATA_WIDTH'(3);
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr = pc_q;
  assign if_valid = state_q == HOLD;
  assign if_pc = if_pc_q;
  assign if_instr = if_instr_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign if_fire = if_valid && if_ready;
  // Normal sequencing first, then a redirect overrides pc, kill and the HOLD exit
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    kill_d = kill_q;
    if_pc_d = if_pc_q;
    if_instr_d = if_instr_q;
    grace_d = grace_q && !req_fire;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: state_d = req_fire ? WAIT : REQ;
      WAIT: if (imem_rsp_valid) begin
        kill_d = 1'b0;
        state_d = (kill_q || redirect_valid) ? REQ : HOLD;
        if (!kill_q && !redirect_valid) begin
          if_pc_d = pc_q;
          if_instr_d = imem_rsp_data;
        end
      end
      HOLD: if (if_fire) begin
        pc_d = pc_q + DATA_WIDTH'(4);
        state_d = REQ;
      end
    endcase
    if (redirect_valid) begin
      pc_d = tgt;
      kill_d = (state_q == REQ) ? req_fire : (state_q == WAIT) ? !imem_rsp_valid : kill_q;
      if (state_q == HOLD) state_d = REQ;
    end
  end
  // State and PC registers; grace marks the window where a pre-reset response may still land
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      kill_q <= 1'b0;
      grace_q <= 1'b1;
      if_pc_q <= '0;
      if_instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      kill_q <= kill_d;
      grace_q <= grace_d;
      if_pc_q <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end
  // A response is legal only in WAIT, or as a late reply to a request issued before reset
  a_rsp_in_wait: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (state_q == WAIT || grace_q));
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus randomized run against a stream-level fetch model
module tb_pc_fetch_ctrl;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, if_valid, if_ready;
  logic [W-1:0] imem_req_addr, imem_rsp_data, redirect_target, if_pc, if_instr;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );
  typedef struct {
    logic rdy, rv;
    logic [W-1:0] rd;
    logic dv;
    logic [W-1:0] tgt;
    logic ifr, ev;
    logic [W-1:0] ea;
    logic fv;
    logic [W-1:0] fp, fi;
  } vec_t;
  vec_t tv[$];
  function automatic logic [W-1:0] f(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic rdy, input logic rv, input logic [W-1:0] rd, input logic dv,
                     input logic [W-1:0] tgt, input logic ifr, input logic ev, input logic [W-1:0] ea,
                     input logic fv, input logic [W-1:0] fp, input logic [W-1:0] fi);
    tv.push_back('{rdy, rv, rd, dv, tgt, ifr, ev, ea, fv, fp, fi});
  endtask
  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      imem_req_ready = tv[i].rdy;
      imem_rsp_valid = tv[i].rv;
      imem_rsp_data = tv[i].rd;
      redirect_valid = tv[i].dv;
      redirect_target = tv[i].tgt;
      if_ready = tv[i].ifr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {imem_req_valid, imem_req_addr, if_valid, tv[i].fv ? {if_pc, if_instr} : 64'h0},
            {tv[i].ev, tv[i].ea, tv[i].fv, tv[i].fv ? {tv[i].fp, tv[i].fi} : 64'h0});
    end
  endtask
  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = 1'b0;
  endtask
  logic pend, hold_chk;
  int cnt, deliv;
  logic [W-1:0] paddr, exp_pc, prev_addr;
  initial begin
    // rdy rv rsp_data dv target ifr | req_v req_addr if_v if_pc if_instr
    add(1,0,0,0,0,1, 1,32'h0,0,0,0);
    add(1,0,0,0,0,1, 0,32'h0,0,0,0);
    add(1,1,32'h13,0,0,1, 0,32'h0,1,32'h0,32'h13);
    add(1,0,0,0,0,1, 1,32'h4,0,0,0);
    add(1,0,0,0,0,1, 0,32'h4,0,0,0);
    add(1,1,32'h13,0,0,1, 0,32'h4,1,32'h4,32'h13);
    add(1,0,0,0,0,1, 1,32'h8,0,0,0);
    add(1,0,0,0,0,0, 0,32'h8,0,0,0);
    add(1,1,32'h00A00093,0,0,0, 0,32'h8,1,32'h8,32'h00A00093);
    for (int k = 0; k < 5; k++) add(1,0,0,0,0,0, 0,32'h8,1,32'h8,32'h00A00093);
    add(1,0,0,0,0,1, 1,32'hC,0,0,0);
    add(1,0,0,0,0,0, 0,32'hC,0,0,0);
    add(0,0,0,1,32'h100,0, 0,32'h100,0,0,0);
    add(0,0,0,0,0,0, 0,32'h100,0,0,0);
    add(0,0,0,0,0,0, 0,32'h100,0,0,0);
    add(0,1,32'hDEAD,0,0,0, 1,32'h100,0,0,0);
    add(1,0,0,0,0,0, 0,32'h100,0,0,0);
    add(1,1,32'h13,0,0,0, 0,32'h100,1,32'h100,32'h13);
    add(0,0,0,0,0,1, 1,32'h104,0,0,0);
    add(1,0,0,1,32'h203,0, 0,32'h200,0,0,0);
    add(0,1,32'hBAD,0,0,0, 1,32'h200,0,0,0);
    add(1,0,0,0,0,0, 0,32'h200,0,0,0);
    add(1,1,32'h13,0,0,0, 0,32'h200,1,32'h200,32'h13);
    add(0,0,0,0,0,1, 1,32'h204,0,0,0);
    add(1,0,0,0,0,0, 0,32'h204,0,0,0);
    add(0,1,32'hBAD,1,32'h203,0, 1,32'h200,0,0,0);
    add(1,0,0,0,0,0, 0,32'h200,0,0,0);
    add(1,1,32'h13,0,0,0, 0,32'h200,1,32'h200,32'h13);
    add(0,0,0,1,32'h0,1, 1,32'h0,0,0,0);
    add(0,0,0,0,0,0, 1,32'h0,0,0,0);
    add(0,0,0,1,32'h40,0, 1,32'h40,0,0,0);
    add(0,0,0,0,0,0, 1,32'h40,0,0,0);
    add(1,0,0,0,0,0, 0,32'h40,0,0,0);
    add(1,1,32'h13,0,0,0, 0,32'h40,1,32'h40,32'h13);
    add(0,0,0,1,32'h80,0, 1,32'h80,0,0,0);
    add(1,0,0,0,0,0, 0,32'h80,0,0,0);
    add(1,1,32'hBAD,0,0,0, 1,32'h0,0,0,0);
    add(1,1,32'hBAD,0,0,0, 0,32'h0,0,0,0);
    add(0,1,32'h13,0,0,0, 0,32'h0,1,32'h0,32'h13);
    add(0,0,0,0,0,1, 1,32'h4,0,0,0);
    add(0,0,0,1,32'hFFFF_FFFF,0, 1,32'hFFFF_FFFC,0,0,0);
    add(1,0,0,0,0,0, 0,32'hFFFF_FFFC,0,0,0);
    add(0,1,32'h13,0,0,0, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h13);
    add(0,0,0,0,0,1, 1,32'h0,0,0,0);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("reset", {imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr}, {1'b0, 32'h0, 1'b0, 64'h0});
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_vec(0, 39);
    #2 rst = 1'b0;
    #1;
    check("async_reset", {imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr}, {1'b0, 32'h0, 1'b0, 64'h0});
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_vec(40, 47);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk) rst = 1'b1;
    pend = 1'b0;
    hold_chk = 1'b0;
    cnt = 0;
    deliv = 0;
    paddr = '0;
    exp_pc = '0;
    prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_chk) check("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
      imem_rsp_valid = pend && cnt == 0;
      imem_rsp_data = f(paddr);
      imem_req_ready = $urandom_range(0, 9) < 6;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 1023);
      if_ready = $urandom_range(0, 9) < 6;
      if (imem_rsp_valid) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_req_valid && imem_req_ready) begin
        check("one_outstanding", pend, 0);
        pend = 1'b1;
        cnt = $urandom_range(0, 3);
        paddr = imem_req_addr;
      end
      if (if_valid && if_ready && !redirect_valid) begin
        check("if_pc", if_pc, exp_pc);
        check("if_instr", if_instr, f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end
      if (redirect_valid) exp_pc = redirect_target & ~32'h3;
      hold_chk = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr = imem_req_addr;
      @(posedge clk);
      #1;
    end
    check("progress", deliv > 50, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
